generation_scheduler: RTL and testbench

GENERATION_SCHEDULER -- requirements
Module: generation_scheduler

---
 rtl/generation_scheduler.sv | 169 ++++++++++++++++
 tb/tb_generation_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/generation_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : generation_scheduler
// Function : Sequences InitPop, Selection and mutation passes for MAX_GEN
//            generations, reporting each completed count over the UART.
// Revision : 1.0 - initial release
// ============================================================================
module generation_scheduler #(
    parameter int MAX_GEN = 16,
    parameter int TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        init_done,
    input  logic        sel_done,
    input  logic        mut_done,
    input  logic        uart_busy,
    output logic        init_start,
    output logic        sel_start,
    output logic        mut_start,
    output logic        uart_transmit,
    output logic [7:0]  uart_byte,
    output logic [15:0] gen_count,
    output logic [2:0]  state_out,
    output logic        busy,
    output logic        error
);

    localparam int                c_WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST  = c_WD_W'(TIMEOUT - 1);
    localparam logic [15:0]       c_GEN_LAST = 16'(MAX_GEN);
    localparam logic [15:0]       c_GEN_SAT  = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_SEL    = 3'd2,
        S_MUT    = 3'd3,
        S_REPORT = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t              r_state;
    logic                r_init_start;
    logic                r_sel_start;
    logic                r_mut_start;
    logic                r_uart_tx;
    logic [7:0]          r_uart_byte;
    logic [15:0]         r_gen;
    logic                r_error;
    logic [c_WD_W-1:0]   r_wd;

    logic                w_wd_expired;

    assign w_wd_expired = (r_wd == c_WD_LAST);

    // A strobe register being high marks the entry cycle of its state; the
    // matching done input is not yet meaningful then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_init_start <= 1'b0;
            r_sel_start  <= 1'b0;
            r_mut_start  <= 1'b0;
            r_uart_tx    <= 1'b0;
            r_uart_byte  <= 8'd0;
            r_gen        <= 16'd0;
            r_error      <= 1'b0;
            r_wd         <= '0;
        end else begin
            r_init_start <= 1'b0;
            r_sel_start  <= 1'b0;
            r_mut_start  <= 1'b0;
            r_uart_tx    <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                r_wd    <= '0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (start) begin
                            r_state      <= S_INIT;
                            r_init_start <= 1'b1;
                            r_gen        <= 16'd0;
                            r_error      <= 1'b0;
                            r_wd         <= '0;
                        end
                    end
                    S_INIT: begin
                        if (init_done && !r_init_start) begin
                            r_state     <= S_SEL;
                            r_sel_start <= 1'b1;
                            r_wd        <= '0;
                        end else if (w_wd_expired) begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                            r_wd    <= '0;
                        end else begin
                            r_wd <= r_wd + 1'b1;
                        end
                    end
                    S_SEL: begin
                        if (sel_done && !r_sel_start) begin
                            r_state     <= S_MUT;
                            r_mut_start <= 1'b1;
                            r_wd        <= '0;
                        end else if (w_wd_expired) begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                            r_wd    <= '0;
                        end else begin
                            r_wd <= r_wd + 1'b1;
                        end
                    end
                    S_MUT: begin
                        if (mut_done && !r_mut_start) begin
                            r_state <= S_REPORT;
                            r_wd    <= '0;
                            if (r_gen != c_GEN_SAT) begin
                                r_gen <= r_gen + 16'd1;
                            end
                        end else if (w_wd_expired) begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                            r_wd    <= '0;
                        end else begin
                            r_wd <= r_wd + 1'b1;
                        end
                    end
                    S_REPORT: begin
                        // No watchdog here: the UART may stall indefinitely.
                        if (r_uart_tx) begin
                            r_wd <= '0;
                            if (r_gen == c_GEN_LAST) begin
                                r_state <= S_DONE;
                            end else begin
                                r_state     <= S_SEL;
                                r_sel_start <= 1'b1;
                            end
                        end else if (!uart_busy) begin
                            r_uart_tx   <= 1'b1;
                            r_uart_byte <= r_gen[7:0];
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_wd    <= '0;
                    end
                endcase
            end
        end
    end

    assign init_start    = r_init_start;
    assign sel_start     = r_sel_start;
    assign mut_start     = r_mut_start;
    assign uart_transmit = r_uart_tx;
    assign uart_byte     = r_uart_byte;
    assign gen_count     = r_gen;
    assign state_out     = r_state;
    assign error         = r_error;
    assign busy          = (r_state == S_INIT) || (r_state == S_SEL) ||
                           (r_state == S_MUT)  || (r_state == S_REPORT);

endmodule
`default_nettype wire

// File: tb/tb_generation_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_generation_scheduler
// Function : Randomized self-checking bench; expected strobe timing is derived
//            arithmetically from the chosen done delays and UART stalls.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_generation_scheduler;

    localparam int MAX_GEN = 2;
    localparam int TIMEOUT = 8;
    localparam int NMAX    = 256;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, init_done, sel_done, mut_done, uart_busy;
    logic        init_start, sel_start, mut_start, uart_transmit;
    logic [7:0]  uart_byte;
    logic [15:0] gen_count;
    logic [2:0]  state_out;
    logic        busy, error;

    generation_scheduler #(.MAX_GEN(MAX_GEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .init_done(init_done), .sel_done(sel_done), .mut_done(mut_done),
        .uart_busy(uart_busy), .init_start(init_start), .sel_start(sel_start),
        .mut_start(mut_start), .uart_transmit(uart_transmit),
        .uart_byte(uart_byte), .gen_count(gen_count), .state_out(state_out),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct { int at; int kind; int data; } ev_t;

    ev_t exp_q[$];
    ev_t act_q[$];
    int  inc_q[$];
    bit  s_start[NMAX], s_abort[NMAX], s_init[NMAX], s_sel[NMAX], s_mut[NMAX];
    bit  s_busy[NMAX], s_rep[NMAX];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc = 0, base = 0, len = 0, exp_state = 0, run_id = 0;
    bit  exp_err = 1'b0;
    int  last_byte = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL run%0d %s: got %0d expected %0d", run_id, tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (init_start)    act_q.push_back('{at: cyc - base, kind: 0, data: 0});
        if (sel_start)     act_q.push_back('{at: cyc - base, kind: 1, data: 0});
        if (mut_start)     act_q.push_back('{at: cyc - base, kind: 2, data: 0});
        if (uart_transmit) act_q.push_back('{at: cyc - base, kind: 3, data: int'(uart_byte)});
    endtask

    function automatic int pick_delay();
        return ($urandom_range(0, 5) == 0) ? TIMEOUT - 1 : int'($urandom_range(1, 5));
    endfunction

    task automatic set_done(input int kind, input int at);
        if (kind == 0) s_init[at] = 1'b1;
        else if (kind == 1) s_sel[at] = 1'b1;
        else s_mut[at] = 1'b1;
    endtask

    // A strobe at cycle c with its done driven in cycle c+d yields the next
    // state at c+d+1; a done never arriving yields ERROR at c+TIMEOUT.
    // noise: 0 none, 1 random, 2 done in every strobe cycle + start while busy
    task automatic plan_run(input bit fixed, input int b1, input int b2,
                            input int stall, input int abrt, input int noise);
        int t, d, b, kind, init_acc, gens;
        bit ended;
        int mut_lo[$];
        int mut_hi[$];
        for (int i = 0; i < NMAX; i++) begin
            s_start[i] = 0; s_abort[i] = 0; s_init[i] = 0; s_sel[i] = 0;
            s_mut[i] = 0; s_busy[i] = 0; s_rep[i] = 0;
        end
        exp_q.delete();
        inc_q.delete();
        s_start[0] = 1'b1;
        t = 1; init_acc = -1; gens = 0; ended = 1'b0;
        exp_err = 1'b0; exp_state = 5; len = 0;
        for (int s = 0; s < 1 + 2 * MAX_GEN && !ended; s++) begin
            kind = (s == 0) ? 0 : (((s % 2) == 1) ? 1 : 2);
            exp_q.push_back('{at: t, kind: kind, data: 0});
            if (noise == 2 || (noise == 1 && $urandom_range(0, 2) == 0)) set_done(kind, t);
            if (s == stall) begin
                if (kind == 2) begin mut_lo.push_back(t); mut_hi.push_back(t + TIMEOUT - 1); end
                len = t + TIMEOUT; exp_state = 6; exp_err = 1'b1; ended = 1'b1;
            end else begin
                d = fixed ? 3 : pick_delay();
                set_done(kind, t + d);
                if (kind == 2) begin mut_lo.push_back(t); mut_hi.push_back(t + d); end
                if (kind == 0) init_acc = t + d;
                if (s == abrt) begin
                    s_abort[t + d] = 1'b1; len = t + d + 1; exp_state = 0; ended = 1'b1;
                end else begin
                    t = t + d + 1;
                    if (kind == 2) begin
                        gens++;
                        inc_q.push_back(t);
                        b = (gens == 1) ? b1 : b2;
                        if (b < 0) b = $urandom_range(0, 12);
                        for (int k = 0; k <= b; k++) s_rep[t + k] = 1'b1;
                        for (int k = 0; k < b; k++) s_busy[t + k] = 1'b1;
                        exp_q.push_back('{at: t + b + 1, kind: 3, data: gens & 255});
                        last_byte = gens & 255;
                        t = t + b + 2;
                    end
                end
            end
        end
        if (!ended) len = t;
        for (int r = 1; r < len; r++) begin
            if (noise == 2) s_start[r] = 1'b1;
            if (noise == 1) begin
                if ($urandom_range(0, 7) == 0) s_start[r] = 1'b1;
                if (init_acc >= 0 && r > init_acc && $urandom_range(0, 5) == 0) s_init[r] = 1'b1;
                if (!s_rep[r] && $urandom_range(0, 3) == 0) s_busy[r] = 1'b1;
                foreach (mut_lo[i])
                    if (r >= mut_lo[i] && r <= mut_hi[i] && $urandom_range(0, 3) == 0) s_sel[r] = 1'b1;
            end
        end
    endtask

    task automatic exec_run(input int tail);
        int rel, exp_gen;
        act_q.delete();
        base = cyc;
        for (int r = 0; r < len + tail; r++) begin
            start = s_start[r]; abort = s_abort[r]; init_done = s_init[r];
            sel_done = s_sel[r]; mut_done = s_mut[r]; uart_busy = s_busy[r];
            tick();
            rel = r + 1;
            exp_gen = 0;
            foreach (inc_q[i]) if (inc_q[i] <= rel) exp_gen++;
            check_eq($sformatf("busy@%0d", rel), busy, rel < len);
            check_eq($sformatf("gen_count@%0d", rel), gen_count, exp_gen);
            check_eq($sformatf("error@%0d", rel), error, (rel < len) ? 1'b0 : exp_err);
            if (rel == 1) check_eq("state_after_start", state_out, 1);
            if (rel >= len) check_eq($sformatf("final_state@%0d", rel), state_out, exp_state);
        end
        start = 0; abort = 0; init_done = 0; sel_done = 0; mut_done = 0; uart_busy = 0;
        check_eq("event_count", act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            check_eq($sformatf("ev%0d_cycle", i), act_q[i].at, exp_q[i].at);
            check_eq($sformatf("ev%0d_kind", i), act_q[i].kind, exp_q[i].kind);
            check_eq($sformatf("ev%0d_data", i), act_q[i].data, exp_q[i].data);
        end
        check_eq("uart_byte_hold", uart_byte, last_byte);
        run_id++;
    endtask

    initial begin
        bit found;
        rst_n = 1'b1; start = 0; abort = 0; init_done = 0; sel_done = 0;
        mut_done = 0; uart_busy = 0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_state", state_out, 0);
        check_eq("rst_strobes", {init_start, sel_start, mut_start, uart_transmit}, 0);
        check_eq("rst_byte", uart_byte, 0);
        check_eq("rst_gen", gen_count, 0);
        check_eq("rst_busy_err", {busy, error}, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_state", state_out, 0);

        plan_run(1'b1, 0, 0, -1, -1, 0);  exec_run(3);   // nominal
        plan_run(1'b1, 10, 0, -1, -1, 0); exec_run(3);   // UART backpressure
        plan_run(1'b1, 0, 0, 1, -1, 0);   exec_run(3);   // SEL timeout
        plan_run(1'b1, 0, 0, -1, 2, 0);   exec_run(3);   // abort with mut_done
        plan_run(1'b1, 0, 0, -1, -1, 2);  exec_run(3);   // ignored done / start
        for (int r = 0; r < 20; r++) begin
            plan_run(1'b0, -1, -1,
                     ((r % 5) == 0) ? int'($urandom_range(0, 4)) : -1,
                     ((r % 5) == 1) ? int'($urandom_range(0, 4)) : -1, 1);
            exec_run(3);
        end

        // Asynchronous reset while in MUT
        start = 1'b1; tick(); start = 1'b0;
        init_done = 1'b1; sel_done = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (state_out == 3'd3) found = 1'b1;
        end
        check_eq("reach_mut", found, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_state", state_out, 0);
        check_eq("async_strobes", {init_start, sel_start, mut_start, uart_transmit}, 0);
        check_eq("async_gen", gen_count, 0);
        check_eq("async_byte_busy_err", {uart_byte, busy, error}, 0);
        init_done = 1'b0; sel_done = 1'b0;
        @(posedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("release_strobes", {init_start, sel_start, mut_start, uart_transmit}, 0);
        check_eq("release_state", state_out, 0);
        last_byte = 0;

        plan_run(1'b1, 0, 0, -1, -1, 0);  exec_run(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
